// File: rtl/m4_fft_pkg.sv
// Shared constants and FSM state type for the 4096-point radix-4 FFT address generator.
package m4_fft_pkg;

  localparam int N_PTS = 4096;
  localparam int N_STG = 6;
  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int PW    = $clog2(N_PTS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_FIN
  } agu_state_t;

endpackage

// File: rtl/r4_addr_map.sv
// Butterfly (b, digit position d) to per-bank addresses, bank rotation and twiddle exponent.
module r4_addr_map
  import m4_fft_pkg::*;
(
  input  logic [AW-1:0]       b,
  input  logic [2:0]          d,
  output logic [3:0][AW-1:0]  addr,
  output logic [1:0]          r,
  output logic [PW-1:0]       tw
);

  logic [3:0]    sh;
  logic [PW-1:0] bx;
  logic [PW-1:0] mask;
  logic [PW-1:0] lo;
  logic [PW-1:0] n0;
  logic [PW-1:0] nm;
  logic [1:0]    bank;

  // Insert a zero digit at position d, derive the digit-sum bank rotation and scatter the four points.
  always_comb begin
    sh   = {d, 1'b0};
    bx   = {2'b00, b};
    mask = (PW'(1) << sh) - PW'(1);
    lo   = bx & mask;
    n0   = ((bx & ~mask) << 2) | lo;
    r    = '0;
    for (int i = 0; i < N_STG; i++) begin
      r = r + n0[2*i +: 2];
    end
    // Low digits select the twiddle; at d=0 the mask is empty so the exponent is 0.
    tw   = lo << (4'd10 - sh);
    addr = '0;
    nm   = '0;
    bank = '0;
    for (int m = 0; m < 4; m++) begin
      bank       = r + 2'(m);
      nm         = n0 | (PW'(m) << sh);
      addr[bank] = nm[PW-1:2];
    end
  end

endmodule

// File: rtl/m4_agu.sv
// Address generator for an in-place 4096-point radix-4 DIF FFT over four SRAM banks.
module m4_agu
  import m4_fft_pkg::*;
#(
  parameter int LAT   = 7,
  parameter int BURST = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          WE,
  output logic [AW-1:0] ADDR0,
  output logic [AW-1:0] ADDR1,
  output logic [AW-1:0] ADDR2,
  output logic [AW-1:0] ADDR3,
  output logic          RVALID,
  output logic [1:0]    RSEL,
  output logic [PW-1:0] TW_E,
  output logic [1:0]    WSEL,
  output logic [2:0]    STAGE
);

  localparam int WAIT_LEN = LAT - BURST + 1;
  localparam int CW       = $clog2(LAT + 2);
  localparam int RW       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(BURST - 1);
  localparam logic [CW-1:0] WT_LAST = CW'((WAIT_LEN > 0) ? WAIT_LEN - 1 : 0);

  agu_state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] b, b_n;
  logic [2:0]    s, s_n;
  logic [2:0]    d_n;
  logic [RW-1:0] idx_n;

  logic [3:0][AW-1:0] map_addr;
  logic [1:0]         map_r;
  logic [PW-1:0]      map_tw;

  logic [3:0][AW-1:0] addr_q;
  logic [1:0]         r_p0;
  logic [PW-1:0]      tw_p0;

  logic [3:0][AW-1:0] rp_addr [BURST];
  logic [1:0]         rp_r    [BURST];

  assign d_n   = 3'(N_STG - 1) - s_n;
  assign idx_n = cnt_n[RW-1:0];

  assign ADDR0 = addr_q[0];
  assign ADDR1 = addr_q[1];
  assign ADDR2 = addr_q[2];
  assign ADDR3 = addr_q[3];

  r4_addr_map u_map (
    .b    (b_n),
    .d    (d_n),
    .addr (map_addr),
    .r    (map_r),
    .tw   (map_tw)
  );

  // Next-state, burst position and butterfly/stage counters.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    b_n   = b;
    s_n   = s;
    unique case (st)
      ST_IDLE: begin
        if (START) begin
          st_n  = ST_RD;
          cnt_n = '0;
          b_n   = '0;
          s_n   = '0;
        end
      end
      ST_RD: begin
        if (cnt == RD_LAST) begin
          st_n  = (WAIT_LEN > 0) ? ST_WAIT : ST_WR;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
          b_n   = b + AW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt == WT_LAST) begin
          st_n  = ST_WR;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_WR: begin
        if (cnt == RD_LAST) begin
          cnt_n = '0;
          if (b == '1 && s == 3'(N_STG - 1)) begin
            st_n = ST_FIN;
          end else begin
            st_n = ST_RD;
            b_n  = b + AW'(1);
            if (b == '1) s_n = s + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_FIN: begin
        st_n = ST_IDLE;
        b_n  = '0;
        s_n  = '0;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // Stage p0 -> outputs: register state and every output; read tags trail addresses by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      b      <= '0;
      s      <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      WE     <= 1'b0;
      addr_q <= '0;
      RVALID <= 1'b0;
      RSEL   <= '0;
      TW_E   <= '0;
      WSEL   <= '0;
      STAGE  <= '0;
      r_p0   <= '0;
      tw_p0  <= '0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      b      <= b_n;
      s      <= s_n;
      BUSY   <= st_n inside {ST_RD, ST_WAIT, ST_WR};
      DONE   <= (st_n == ST_FIN);
      WE     <= (st_n == ST_WR);
      RVALID <= (st == ST_RD);
      RSEL   <= r_p0;
      TW_E   <= tw_p0;
      STAGE  <= s_n;
      if (st_n == ST_RD) begin
        addr_q <= map_addr;
        r_p0   <= map_r;
        tw_p0  <= map_tw;
      end else if (st_n == ST_WR) begin
        addr_q <= rp_addr[idx_n];
        WSEL   <= rp_r[idx_n];
      end
    end
  end

  // Replay buffer: remember each read address set so the write burst lands in place.
  always_ff @(posedge CLK) begin
    if (st_n == ST_RD) begin
      rp_addr[idx_n] <= map_addr;
      rp_r[idx_n]    <= map_r;
    end
  end

endmodule

// File: tb/tb_m4_agu.sv
// Self-checking bench for m4_agu: point-level reference model, bank scoreboard, reset scenarios.
module tb_m4_agu;

  localparam int LAT   = 7;
  localparam int BURST = 8;
  localparam int P     = LAT + BURST + 1;
  localparam int BPS   = 1024 / BURST;
  localparam int NB    = 6 * BPS;
  localparam int TOTAL = NB * P + 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        BUSY, DONE, WE, RVALID;
  logic [9:0]  ADDR0, ADDR1, ADDR2, ADDR3;
  logic [1:0]  RSEL, WSEL;
  logic [11:0] TW_E;
  logic [2:0]  STAGE;

  int checks = 0;
  int errors = 0;
  int rd_sb [4][1024];
  int wr_sb [4][1024];

  m4_agu #(.LAT(LAT), .BURST(BURST)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .WE(WE),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
    .RVALID(RVALID), .RSEL(RSEL), .TW_E(TW_E), .WSEL(WSEL), .STAGE(STAGE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int digsum4(input int n);
    int t, sum;
    t = n;
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      sum += t % 4;
      t = t / 4;
    end
    return sum;
  endfunction

  // Each point lives in bank (digit sum mod 4) at word n/4.
  function automatic void ref_map(input int b, input int s, output logic [3:0][9:0] a,
                                  output int r, output int tw);
    int d, base, n0, n;
    d    = 5 - s;
    base = 1 << (2 * d);
    n0   = (b / base) * base * 4 + (b % base);
    a    = '1;
    for (int m = 0; m < 4; m++) begin
      n = n0 + m * base;
      a[2'(digsum4(n) % 4)] = 10'(n / 4);
    end
    r  = digsum4(n0) % 4;
    tw = ((n0 % base) * (1 << (10 - 2 * d))) % 4096;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [62:0] all_outs();
    return {BUSY, DONE, WE, ADDR0, ADDR1, ADDR2, ADDR3, RVALID, RSEL, TW_E, WSEL, STAGE};
  endfunction

  // Compare cycle k (k=1 is the first cycle after START is taken) against the model.
  task automatic check_cycle(input int k, input bit sb_en);
    int j, pos, s, b0, er, et, bad;
    bit e_rd, e_we, e_rv, e_busy, e_done;
    logic [3:0][9:0] ea, oa;
    oa = {ADDR3, ADDR2, ADDR1, ADDR0};
    j = 0; pos = 0; s = 0; b0 = 0;
    if (k <= NB * P) begin
      j = (k - 1) / P;
      pos = (k - 1) % P;
      s = j / BPS;
      b0 = (j % BPS) * BURST;
      e_rd = (pos < BURST);
      e_we = (pos >= LAT + 1) && (pos <= LAT + BURST);
      e_rv = (pos >= 1) && (pos <= BURST);
      e_busy = 1'b1;
      e_done = 1'b0;
    end else begin
      e_rd = 1'b0; e_we = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
      e_done = (k == NB * P + 1);
    end
    checks++;
    if ({BUSY, DONE, WE, RVALID} !== {e_busy, e_done, e_we, e_rv}) begin
      errors++;
      $display("FAIL ctrl k=%0d busy/done/we/rvalid got %b want %b", k,
               {BUSY, DONE, WE, RVALID}, {e_busy, e_done, e_we, e_rv});
    end
    if (e_busy) begin
      checks++;
      if (STAGE !== 3'(s)) begin
        errors++;
        $display("FAIL stage k=%0d got %0d want %0d", k, STAGE, s);
      end
    end
    if (e_rd) begin
      ref_map(b0 + pos, s, ea, er, et);
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL rd_addr k=%0d got %h want %h", k, oa, ea);
      end
      if (sb_en && !$isunknown(oa))
        for (int bk = 0; bk < 4; bk++) rd_sb[bk][oa[bk]]++;
    end
    if (e_rv) begin
      ref_map(b0 + pos - 1, s, ea, er, et);
      checks++;
      if ({RSEL, TW_E} !== {2'(er), 12'(et)}) begin
        errors++;
        $display("FAIL rtag k=%0d got rsel=%0d tw=%0d want rsel=%0d tw=%0d", k, RSEL, TW_E, er, et);
      end
    end
    if (e_we) begin
      ref_map(b0 + pos - LAT - 1, s, ea, er, et);
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL wr_addr k=%0d got %h want %h", k, oa, ea);
      end
      checks++;
      if (WSEL !== 2'(er)) begin
        errors++;
        $display("FAIL wsel k=%0d got %0d want %0d", k, WSEL, er);
      end
      if (sb_en && !$isunknown(oa))
        for (int bk = 0; bk < 4; bk++) wr_sb[bk][oa[bk]]++;
    end
    if (sb_en && e_busy && pos == P - 1 && (j % BPS) == BPS - 1) begin
      bad = 0;
      for (int bk = 0; bk < 4; bk++)
        for (int a = 0; a < 1024; a++) begin
          if (rd_sb[bk][a] != 1 || wr_sb[bk][a] != 1) bad++;
          rd_sb[bk][a] = 0;
          wr_sb[bk][a] = 0;
        end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL scoreboard stage=%0d bad_locations got %0d want 0", s, bad);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    START = 1'b1;
    tick();
    tick();
    checks++;
    if (all_outs() !== 63'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    RST = 1'b0;
    START = 1'b0;
    tick();
    checks++;
    if ({BUSY, DONE, WE} !== 3'b000) begin
      errors++;
      $display("FAIL reset_over_start busy/done/we got %b want 000", {BUSY, DONE, WE});
    end
  endtask

  task automatic test_known_vectors();
    int k;
    START = 1'b1;
    tick();
    START = 1'b0;
    k = 1;
    checks++;
    if ({ADDR0, ADDR1, ADDR2, ADDR3, BUSY} !== {10'd0, 10'd256, 10'd512, 10'd768, 1'b1}) begin
      errors++;
      $display("FAIL vec_s0_b0 got %0d/%0d/%0d/%0d busy=%b want 0/256/512/768 busy=1",
               ADDR0, ADDR1, ADDR2, ADDR3, BUSY);
    end
    tick(); k++;
    checks++;
    if ({ADDR0, ADDR1, ADDR2, ADDR3} !== {10'd768, 10'd0, 10'd256, 10'd512}) begin
      errors++;
      $display("FAIL vec_s0_b1 got %0d/%0d/%0d/%0d want 768/0/256/512", ADDR0, ADDR1, ADDR2, ADDR3);
    end
    checks++;
    if ({RVALID, RSEL, TW_E} !== {1'b1, 2'd0, 12'd0}) begin
      errors++;
      $display("FAIL vec_tag_b0 got rv=%b rsel=%0d tw=%0d want 1/0/0", RVALID, RSEL, TW_E);
    end
    tick(); k++;
    checks++;
    if ({RSEL, TW_E} !== {2'd1, 12'd1}) begin
      errors++;
      $display("FAIL vec_tag_b1 got rsel=%0d tw=%0d want 1/1", RSEL, TW_E);
    end
    while (k < 8) begin tick(); k++; end
    checks++;
    if (WE !== 1'b0) begin
      errors++;
      $display("FAIL we_before_9 got %b want 0", WE);
    end
    tick(); k++;
    checks++;
    if ({WE, WSEL, ADDR0, ADDR1, ADDR2, ADDR3} !== {1'b1, 2'd0, 10'd0, 10'd256, 10'd512, 10'd768}) begin
      errors++;
      $display("FAIL first_write k=9 got we=%b wsel=%0d %0d/%0d/%0d/%0d want 1 0 0/256/512/768",
               WE, WSEL, ADDR0, ADDR1, ADDR2, ADDR3);
    end
    tick(); k++;
    checks++;
    if ({WE, WSEL, ADDR0, ADDR1, ADDR2, ADDR3} !== {1'b1, 2'd1, 10'd768, 10'd0, 10'd256, 10'd512}) begin
      errors++;
      $display("FAIL second_write k=10 got we=%b wsel=%0d %0d/%0d/%0d/%0d want 1 1 768/0/256/512",
               WE, WSEL, ADDR0, ADDR1, ADDR2, ADDR3);
    end
    while (k < 640 * P + 6) begin tick(); k++; end
    checks++;
    if ({STAGE, ADDR0, ADDR1, ADDR2, ADDR3} !== {3'd5, 10'd5, 10'd5, 10'd5, 10'd5}) begin
      errors++;
      $display("FAIL vec_s5_b5 got stage=%0d %0d/%0d/%0d/%0d want 5 5/5/5/5",
               STAGE, ADDR0, ADDR1, ADDR2, ADDR3);
    end
    tick(); k++;
    checks++;
    if ({RSEL, TW_E} !== {2'd2, 12'd0}) begin
      errors++;
      $display("FAIL vec_s5_tag got rsel=%0d tw=%0d want 2/0", RSEL, TW_E);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= TOTAL + 1; k++) begin
      check_cycle(k, 1'b1);
      if (k == TOTAL) START = 1'b1;
      else if (k < TOTAL) START = ($urandom_range(0, 99) < 3);
      else START = 1'b0;
      tick();
    end
    START = 1'b0;
  endtask

  task automatic test_reset_mid();
    int kmid;
    kmid = 3 * BPS * P + 1 + int'($urandom_range(0, BPS * P - 1));
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= kmid; k++) begin
      check_cycle(k, 1'b0);
      if (k == kmid) RST = 1'b1;
      tick();
    end
    RST = 1'b0;
    checks++;
    if (all_outs() !== 63'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs kmid=%0d got %h want 0", kmid, all_outs());
    end
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      checks++;
      if ({BUSY, DONE, WE} !== 3'b000) begin
        errors++;
        $display("FAIL after_abort cyc=%0d busy/done/we got %b want 000", i, {BUSY, DONE, WE});
      end
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 3 * P; k++) begin
      check_cycle(k, 1'b0);
      tick();
    end
  endtask

  initial begin
    for (int bk = 0; bk < 4; bk++)
      for (int a = 0; a < 1024; a++) begin
        rd_sb[bk][a] = 0;
        wr_sb[bk][a] = 0;
      end
    #1;
    test_reset();
    test_known_vectors();
    test_full_run();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m4_agu.md
M4_AGU -- requirements
Module: m4_agu

Interface
REQ-001 LAT, 7: butterfly datapath latency in cycles, from Q valid to D ready; legal range LAT >= BURST-1.
REQ-002 BURST, 8: butterflies per read/write burst; power of 2, 1..64, divides 1024.
REQ-003 CLK  in  1  single clock; all logic on posedge CLK.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 START  in  1  one-cycle request to run a full 4096-point radix-4 DIF pass set.
REQ-006 BUSY  out  1  high while a transform runs.
REQ-007 DONE  out  1  one-cycle pulse after the final write.
REQ-008 WE  out  1  common write enable to all four SRAM banks.
REQ-009 ADDR0..ADDR3  out  10 each  per-bank word address.
REQ-010 RVALID  out  1  high in the cycle bank Q outputs hold read data.
REQ-011 RSEL  out  2  read rotation r, aligned with RVALID; datapath input m = Q[(r+m) mod 4].
REQ-012 TW_E  out  12  twiddle base exponent, aligned with RVALID; output m is scaled by W4096^(m*TW_E).
REQ-013 WSEL  out  2  write rotation, valid while WE=1; D[(WSEL+m) mod 4] = datapath output m.
REQ-014 STAGE  out  3  current stage s, 0..5.

Function
REQ-015 Butterfly index b is 10 bits (0..1023); stage s uses digit position d=5-s.
REQ-016 Base point n0 = b with 2'b00 inserted at bits [2d+1:2d]; points n_m = n0 + m*4^d, m=0..3.
REQ-017 Rotation r = (sum of the six base-4 digits of n0) mod 4; ADDR[(r+m) mod 4] = n_m[11:2].
REQ-018 TW_E = (n0 mod 4^d) * 4^(5-d), taken mod 4096; TW_E = 0 when d=0.
REQ-019 FSM states: IDLE, RD, WAIT, WR, FIN.
REQ-020 IDLE, START=1 at cycle t: RD at t+1 with b=0, s=0, BUSY=1.
REQ-021 RD: BURST cycles, WE=0, one butterfly address set per cycle, b incrementing.
REQ-022 RD: each address set, r and TW_E are pushed into a BURST-deep replay register array.
REQ-023 RVALID, RSEL and TW_E are asserted one cycle after each RD cycle (SRAM read latency 1).
REQ-024 For a burst starting at cycle c, WE=1 on cycles c+LAT+1 .. c+LAT+BURST.
REQ-025 During those write cycles, ADDRk and WSEL replay the stored read values in order (in-place update).
REQ-026 WAIT covers the gap between RD and WR; WE=0 and the ADDR outputs are held.
REQ-027 After WR the next burst's RD begins the next cycle; the burst period is LAT+BURST+1 cycles.
REQ-028 When b wraps from 1023 to 0, s increments; after s=5 the FSM enters FIN.
REQ-029 FIN: DONE=1 and BUSY=0 for one cycle, then IDLE.
REQ-030 Total duration START to DONE is 6*(1024/BURST)*(LAT+BURST+1)+1 cycles; with defaults that is 12289.
REQ-031 START while BUSY=1 or in FIN is ignored.
REQ-032 Reads and writes never coincide; WE=1 never overlaps RD.
REQ-033 All outputs are registered.

Reset
REQ-034 RST=1 at a posedge forces IDLE and sets b=0 and s=0.
REQ-035 RST=1 at a posedge clears every output to 0: BUSY, DONE, WE, ADDR0..3, RVALID, RSEL, TW_E, WSEL, STAGE.
REQ-036 Reset during a transform aborts it: no DONE, and no further WE.
REQ-037 RST overrides a simultaneous START.

Structure
REQ-038 Shared package m4_fft_pkg holds N_PTS=4096, N_STG=6, AW=10, DW=64 and the FSM state enum.
REQ-039 Combinational sub-module r4_addr_map computes (b, d) -> ADDR0..3, r, TW_E; it is reused by the datapath bench model.

Verification
REQ-040 s=0, b=0 -> ADDR0..3 = 0/256/512/768, RSEL=0, TW_E=0.
REQ-041 s=0, b=1 -> ADDR0=768, ADDR1=0, ADDR2=256, ADDR3=512, RSEL=1, TW_E=1.
REQ-042 s=5, b=5 -> all ADDR=5, RSEL=2, TW_E=0.
REQ-043 Defaults, START at cycle 0 -> first WE at cycle 9 repeating burst-0 addresses, DONE at cycle 12289, and WE never coincides with RD.
REQ-044 RST asserted mid-stage 3 -> next cycle all outputs 0; later START restarts at s=0, b=0.
REQ-045 Scoreboard over a full run: every (bank, addr) is read once and written once per stage, and no two points of a butterfly share a bank.
